// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encoding, widths and the receiver register set.
package uart_rx_pkg;

    localparam int DIV_W      = 24;  // baud divisor width
    localparam int MAX_DATA_W = 9;   // widest data word
    localparam int CNT_W      = 4;   // tick-in-bit and bit counters (OSR <= 16)

    // Encoding is shared with the transmitter.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        DATA  = 4'd2,
        STOP  = 4'd3
    } uart_state_e;

    // Complete receiver state; all-zero is the reset/clear value.
    typedef struct packed {
        uart_state_e             state;
        logic [CNT_W-1:0]        tick_cnt;  // oversample tick within current bit
        logic [CNT_W-1:0]        bit_cnt;   // data or stop bit index
        logic [MAX_DATA_W-1:0]   word;      // word being assembled
        logic [1:0]              smp;       // first two of the three majority samples
        logic                    ferr;      // a stop sample was low in this frame
        logic                    d9;        // data9b latched at start
        logic                    s2;        // stop2b latched at start
        logic                    wr;        // rf_write pulse
        logic [MAX_DATA_W-1:0]   wbyte;     // last word pushed
        logic                    fe_p;      // frame_err pulse
        logic                    ov_p;      // overrun_err pulse
    } rx_regs_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-FIFO write port: the receiver pushes words, the FIFO reports full.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                  rf_write;
    logic [MAX_DATA_W-1:0] rf_wbyte;
    logic                  rf_full;

    modport master (output rf_write, output rf_wbyte, input rf_full);
    modport slave  (input rf_write, input rf_wbyte, output rf_full);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one clk-wide tick every ckdiv+1 clocks.
module uart_baud_tick
    import uart_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic [DIV_W-1:0] ckdiv,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    // ckdiv is read only at reload, so a new value takes effect on the next period.
    assign tick = (cnt_q == '0);

    // Down counter reloading ckdiv when it reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!clr_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= ckdiv;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, start detection, majority sampling, 8/9 data bits,
// 1/2 stop bits, push to receive FIFO with frame and overrun error pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic [DIV_W-1:0] ckdiv,
    input  logic             data9b,
    input  logic             stop2b,
    input  logic             uart_rxd,
    output logic             rxbusy,
    output logic             frame_err,
    output logic             overrun_err,
    uart_rx_if.master        rf
);

    localparam logic [CNT_W-1:0] TICK_LO   = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OSR / 2);
    localparam logic [CNT_W-1:0] TICK_HI   = CNT_W'(OSR / 2 + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OSR - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   rxd_prev_q;
    logic                   rxd_s;
    logic                   line_vld;
    logic                   fall;
    logic                   maj;
    logic                   frame;
    rx_regs_t               r_q;
    rx_regs_t               r_d;

    uart_baud_tick u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_n (clr_n),
        .ckdiv (ckdiv),
        .tick  (tick)
    );

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign line_vld = vld_q[SYNC_STAGES-1];
    // The previous-value flop only holds 1 once a real high has come through the
    // synchronizer, so a line already low at reset release never looks like an edge.
    assign fall     = line_vld & rxd_prev_q & ~rxd_s;
    assign maj      = (r_q.smp[0] & r_q.smp[1]) | (r_q.smp[0] & rxd_s) | (r_q.smp[1] & rxd_s);
    assign frame    = r_q.ferr | ~maj;

    assign rxbusy      = (r_q.state != IDLE);
    assign rf.rf_write = r_q.wr;
    assign rf.rf_wbyte = r_q.wbyte;
    assign frame_err   = r_q.fe_p;
    assign overrun_err = r_q.ov_p;

    // Input synchronizer (idle-high reset), flush tracker and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            vld_q      <= '0;
            rxd_prev_q <= 1'b0;
        end else if (!clr_n) begin
            sync_q     <= '1;
            vld_q      <= '0;
            rxd_prev_q <= 1'b0;
        end else begin
            sync_q     <= (sync_q << 1) | SYNC_STAGES'(uart_rxd);
            vld_q      <= (vld_q << 1) | SYNC_STAGES'(1'b1);
            rxd_prev_q <= rxd_s & line_vld;
        end
    end

    // FSM and datapath register; clear and reset both return everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (!clr_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // Next-state logic: bit timing, sampling, shifting and completion.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        r_d      = r_q;
        r_d.wr   = 1'b0;
        r_d.fe_p = 1'b0;
        r_d.ov_p = 1'b0;

        if (tick && r_q.state != IDLE) begin
            r_d.tick_cnt = r_q.tick_cnt + 1'b1;
            if (r_q.tick_cnt == TICK_LO)  r_d.smp[0] = rxd_s;
            if (r_q.tick_cnt == TICK_MID) r_d.smp[1] = rxd_s;
        end

        unique case (r_q.state)
            IDLE: begin
                if (fall) begin
                    r_d.state    = START;
                    r_d.tick_cnt = '0;
                    r_d.bit_cnt  = '0;
                    r_d.word     = '0;
                    r_d.ferr     = 1'b0;
                    r_d.d9       = data9b;
                    r_d.s2       = stop2b;
                end
            end

            START: begin
                if (tick) begin
                    if (r_q.tick_cnt == TICK_HI && maj) begin
                        r_d.state = IDLE;  // glitch, not a start bit
                    end else if (r_q.tick_cnt == TICK_LAST) begin
                        r_d.state    = DATA;
                        r_d.tick_cnt = '0;
                        r_d.bit_cnt  = '0;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (r_q.tick_cnt == TICK_HI) begin
                        r_d.word[r_q.bit_cnt] = maj;
                    end
                    if (r_q.tick_cnt == TICK_LAST) begin
                        r_d.tick_cnt = '0;
                        if (r_q.bit_cnt == (r_q.d9 ? CNT_W'(8) : CNT_W'(7))) begin
                            r_d.state   = STOP;
                            r_d.bit_cnt = '0;
                        end else begin
                            r_d.bit_cnt = r_q.bit_cnt + 1'b1;
                        end
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (r_q.tick_cnt == TICK_HI) begin
                        if (r_q.bit_cnt == CNT_W'(r_q.s2)) begin
                            // Finish mid-way through the last stop bit so the next
                            // start edge can arrive as early as the sender allows.
                            r_d.state = IDLE;
                            r_d.fe_p  = frame;
                            if (rf.rf_full) begin
                                r_d.ov_p = 1'b1;
                            end else begin
                                r_d.wr    = 1'b1;
                                r_d.wbyte = r_q.word;
                            end
                        end else begin
                            r_d.ferr = frame;
                        end
                    end
                    if (r_q.tick_cnt == TICK_LAST) begin
                        r_d.tick_cnt = '0;
                        r_d.bit_cnt  = r_q.bit_cnt + 1'b1;
                    end
                end
            end

            default: r_d.state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a serial line driver plus a pulse monitor; expected
// words, counts and timing windows are hand-computed constants.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr_n;
    logic [DIV_W-1:0] ckdiv;
    logic             data9b;
    logic             stop2b;
    logic             uart_rxd;
    logic             rxbusy;
    logic             frame_err;
    logic             overrun_err;

    uart_rx_if rf_if ();

    uart_rx #(.OSR(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_n       (clr_n),
        .ckdiv       (ckdiv),
        .data9b      (data9b),
        .stop2b      (stop2b),
        .uart_rxd    (uart_rxd),
        .rxbusy      (rxbusy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rf          (rf_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;

    // Monitor state, written only by the monitor block.
    int         wr_cnt     = 0;
    int         fe_cnt     = 0;
    int         fe_wr_cnt  = 0;
    int         ov_cnt     = 0;
    int         fall_cyc   = -1;
    int         rise_cyc   = -1;
    logic       busy_d     = 1'b0;
    logic [8:0] last_word  = '0;

    // Snapshots taken before each scenario.
    int w0, f0, fw0, o0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample DUT outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rf_if.rf_write) begin
            wr_cnt    = wr_cnt + 1;
            last_word = rf_if.rf_wbyte;
            if (frame_err) fe_wr_cnt = fe_wr_cnt + 1;
        end
        if (frame_err)   fe_cnt = fe_cnt + 1;
        if (overrun_err) ov_cnt = ov_cnt + 1;
        if (busy_d && !rxbusy) fall_cyc = cyc;
        if (!busy_d && rxbusy) rise_cyc = cyc;
        busy_d = rxbusy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        w0  = wr_cnt;
        f0  = fe_cnt;
        fw0 = fe_wr_cnt;
        o0  = ov_cnt;
    endtask

    task automatic hold_bit(input logic v, input int bclk);
        uart_rxd = v;
        repeat (bclk) @(posedge clk);
        #1;
    endtask

    // One frame; flip inverts data9b/stop2b after the start bit to show they were latched.
    task automatic send_frame(input logic [8:0] w, input logic d9, input logic s2,
                              input int bclk, input logic stop_lo, input logic flip);
        data9b = d9;
        stop2b = s2;
        @(posedge clk);
        #1;
        t0 = cyc;
        hold_bit(1'b0, bclk);
        if (flip) begin
            data9b = ~d9;
            stop2b = ~s2;
        end
        for (int j = 0; j < (d9 ? 9 : 8); j++) hold_bit(w[j], bclk);
        for (int j = 0; j < (s2 ? 2 : 1); j++) hold_bit(~stop_lo, bclk);
        uart_rxd = 1'b1;
        data9b   = d9;
        stop2b   = s2;
    endtask

    initial begin
        logic [8:0] w;
        logic [8:0] exp_w;
        logic       d9;
        logic       s2;

        rst_n          = 1'b0;
        clr_n          = 1'b1;
        ckdiv          = '0;
        data9b         = 1'b0;
        stop2b         = 1'b0;
        uart_rxd       = 1'b0;  // line low through reset release
        rf_if.rf_full  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_rxbusy",   32'(rxbusy),         32'h0);
        check("rst_write",    32'(rf_if.rf_write), 32'h0);
        check("rst_wbyte",    32'(rf_if.rf_wbyte), 32'h0);
        check("rst_frame",    32'(frame_err),      32'h0);
        check("rst_overrun",  32'(overrun_err),    32'h0);

        // Line already low at release must not start a frame.
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("low_release_nowrite", 32'(wr_cnt),   32'h0);
        check("low_release_nobusy",  32'(rise_cyc), 32'hFFFF_FFFF);
        uart_rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // 8N1 0x55 at 16 clk/bit.
        snap();
        send_frame(9'h055, 1'b0, 1'b0, 16, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("b55_writes",  32'(wr_cnt - w0), 32'd1);
        check("b55_word",    32'(last_word),   32'h055);
        check("b55_frame",   32'(fe_cnt - f0), 32'd0);
        check("b55_overrun", 32'(ov_cnt - o0), 32'd0);

        // 9 data bits, 2 stop bits; completion lands near the middle of stop bit 2
        // (offset 11*16+13 = 189 clk from the start edge with 2-flop sync).
        snap();
        send_frame(9'h1A5, 1'b1, 1'b1, 16, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("w1a5_writes", 32'(wr_cnt - w0), 32'd1);
        check("w1a5_word",   32'(last_word),   32'h1A5);
        check("w1a5_busy_fall_mid_stop2",
              32'((fall_cyc - t0 >= 183) && (fall_cyc - t0 <= 191)), 32'd1);
        data9b = 1'b0;
        stop2b = 1'b0;

        // False start: 5-tick low pulse.
        snap();
        @(posedge clk);
        #1;
        uart_rxd = 1'b0;
        t0 = cyc;
        repeat (5) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_nowrite",   32'(wr_cnt - w0), 32'd0);
        check("glitch_busy_rose", 32'(rise_cyc > t0), 32'd1);
        check("glitch_busy_fall_early",
              32'((fall_cyc > t0) && (fall_cyc - t0 <= 18)), 32'd1);

        // Frame error: 0x3C with low stop bit, still written.
        snap();
        send_frame(9'h03C, 1'b0, 1'b0, 16, 1'b1, 1'b0);
        repeat (24) @(posedge clk);
        #1;
        check("ferr_writes",     32'(wr_cnt - w0),     32'd1);
        check("ferr_word",       32'(last_word),       32'h03C);
        check("ferr_same_clk",   32'(fe_wr_cnt - fw0), 32'd1);
        check("ferr_pulses",     32'(fe_cnt - f0),     32'd1);

        // Overrun: FIFO full at completion of 0xA7, then 0x12 with room.
        snap();
        rf_if.rf_full = 1'b1;
        send_frame(9'h0A7, 1'b0, 1'b0, 16, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rf_if.rf_full = 1'b0;
        check("ovr_nowrite",   32'(wr_cnt - w0),        32'd0);
        check("ovr_pulse",     32'(ov_cnt - o0),        32'd1);
        check("ovr_hold_word", 32'(rf_if.rf_wbyte),     32'h03C);
        check("ovr_noframe",   32'(fe_cnt - f0),        32'd0);
        snap();
        send_frame(9'h012, 1'b0, 1'b0, 16, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("after_ovr_writes", 32'(wr_cnt - w0), 32'd1);
        check("after_ovr_word",   32'(last_word),   32'h012);

        // Break: line held low gives one zero word with frame error, then silence.
        snap();
        @(posedge clk);
        #1;
        uart_rxd = 1'b0;
        repeat (16 * 16) @(posedge clk);
        #1;
        check("break_writes", 32'(wr_cnt - w0),     32'd1);
        check("break_word",   32'(last_word),       32'h000);
        check("break_ferr",   32'(fe_wr_cnt - fw0), 32'd1);
        check("break_idle",   32'(rxbusy),          32'd0);
        uart_rxd = 1'b1;
        repeat (48) @(posedge clk);
        #1;

        // Loopback at 160 clk/bit against ckdiv=9, format changing between frames.
        ckdiv = 24'd9;
        repeat (20) @(posedge clk);
        #1;
        snap();
        for (int i = 0; i < 24; i++) begin
            w     = 9'($urandom);
            d9    = i[0];
            s2    = i[1];
            exp_w = d9 ? w : {1'b0, w[7:0]};
            send_frame(w, d9, s2, 160, 1'b0, i[2]);
            repeat (4) @(posedge clk);
            #1;
            check("loop_writes", 32'(wr_cnt - w0 - i), 32'd1);
            check("loop_word",   32'(last_word),       32'(exp_w));
        end
        check("loop_noframe",   32'(fe_cnt - f0), 32'd0);
        check("loop_nooverrun", 32'(ov_cnt - o0), 32'd0);

        // Clear mid-frame: partial word dropped, registers back to reset values.
        snap();
        data9b = 1'b0;
        stop2b = 1'b0;
        @(posedge clk);
        #1;
        hold_bit(1'b0, 160);
        hold_bit(1'b1, 320);
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        check("clr_busy",  32'(rxbusy),          32'd0);
        check("clr_wbyte", 32'(rf_if.rf_wbyte),  32'h000);
        repeat (1600) @(posedge clk);
        #1;
        check("clr_nowrite", 32'(wr_cnt - w0), 32'd0);
        check("clr_noerr",   32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
